// File: rtl/reg_glitchsched_if.sv
// Host register bus shared by all reg_* slaves. The host drives it and each slave answers,
// with read data OR-combined across slaves.
interface reg_glitchsched_if;
   logic [5:0]  reg_address;
   logic [15:0] reg_bytecnt;
   logic [7:0]  reg_datai;
   logic [7:0]  reg_datao;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;
   logic [5:0]  reg_hypaddress;
   logic [15:0] reg_hyplen;

   modport master (
      output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
             reg_addrvalid, reg_hypaddress,
      input  reg_datao, reg_hyplen
   );

   modport slave (
      input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
             reg_addrvalid, reg_hypaddress,
      output reg_datao, reg_hyplen
   );
endinterface

// File: rtl/reg_glitchsched.sv
// Glitch trigger scheduler. A synchronized rising edge on trig_i starts a counter, and the
// counter fires one-cycle pulses on each enabled glitch channel at its programmed delay.
module reg_glitchsched #(
   parameter logic [5:0] SCHED_CTRL_ADDR   = 6'd58,
   parameter logic [5:0] SCHED_DELAY_ADDR  = 6'd59,
   parameter logic [5:0] SCHED_STATUS_ADDR = 6'd60
) (
   input  logic             clk,
   input  logic             reset_i,
   reg_glitchsched_if.slave bus,
   input  logic             trig_i,
   output logic [1:0]       glitch_trig_o,
   output logic             armed_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] d0_q, d0_d;
   logic [31:0] d1_q, d1_d;
   logic        en0_q, en0_d;
   logic        en1_q, en1_d;
   logic        autorearm_q, autorearm_d;
   logic        missed_q, missed_d;
   logic        arm_rej_q, arm_rej_d;
   logic        trig_s1_q, trig_s1_d;
   logic        trig_s2_q, trig_s2_d;
   logic        trig_s3_q, trig_s3_d;
   logic [1:0]  glitch_q, glitch_d;

   logic        hit_ctrl, hit_delay, hit_status;
   logic        bc_in_range;
   logic        ctrl_wr, delay_wr, arm_wr, abort_wr;
   logic        trig_edge, sched_open;
   logic [31:0] max_d;
   logic [31:0] delay_word;
   logic [7:0]  datao;
   logic [15:0] hyplen;

   // Run length is set by the later of the enabled channels; with none enabled the run ends at once.
   function automatic logic [31:0] sel_max(input logic e0, input logic e1,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] m;
      if (e0 && e1)
         m = (a > b) ? a : b;
      else if (e0)
         m = a;
      else if (e1)
         m = b;
      else
         m = 32'd0;
      return m;
   endfunction

   always_comb begin : decode
      hit_ctrl    = bus.reg_addrvalid && (bus.reg_address == SCHED_CTRL_ADDR);
      hit_delay   = bus.reg_addrvalid && (bus.reg_address == SCHED_DELAY_ADDR);
      hit_status  = bus.reg_addrvalid && (bus.reg_address == SCHED_STATUS_ADDR);
      bc_in_range = (bus.reg_bytecnt[15:3] == 13'd0);
      ctrl_wr     = bus.reg_write && hit_ctrl;
      delay_wr    = bus.reg_write && hit_delay && bc_in_range;
      arm_wr      = ctrl_wr && bus.reg_datai[0];
      abort_wr    = ctrl_wr && bus.reg_datai[1];
      trig_edge   = trig_s2_q && !trig_s3_q;
      sched_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);
      max_d       = sel_max(en0_q, en1_q, d0_q, d1_q);
   end

   always_comb begin : next_state
      state_d     = state_q;
      cnt_d       = cnt_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      en0_d       = en0_q;
      en1_d       = en1_q;
      autorearm_d = autorearm_q;
      missed_d    = missed_q;
      arm_rej_d   = arm_rej_q;
      glitch_d    = 2'b00;
      trig_s1_d   = trig_i;
      trig_s2_d   = trig_s1_q;
      trig_s3_d   = trig_s2_q;

      if (ctrl_wr) begin
         en0_d       = bus.reg_datai[2];
         en1_d       = bus.reg_datai[3];
         autorearm_d = bus.reg_datai[4];
      end

      // Delays are frozen while a schedule is pending or running.
      if (delay_wr && sched_open) begin
         if (bus.reg_bytecnt[2])
            d1_d[{bus.reg_bytecnt[1:0], 3'b000} +: 8] = bus.reg_datai;
         else
            d0_d[{bus.reg_bytecnt[1:0], 3'b000} +: 8] = bus.reg_datai;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm_wr && !abort_wr) begin
               if (bus.reg_datai[2] || bus.reg_datai[3]) begin
                  state_d  = ST_ARMED;
                  missed_d = 1'b0;
               end else begin
                  arm_rej_d = 1'b1;
               end
            end
         end
         ST_ARMED: begin
            if (trig_edge) begin
               state_d = ST_RUN;
               cnt_d   = 32'd0;
            end
         end
         ST_RUN: begin
            cnt_d       = cnt_q + 32'd1;
            glitch_d[0] = en0_q && (cnt_q == d0_q);
            glitch_d[1] = en1_q && (cnt_q == d1_q);
            if (trig_edge)
               missed_d = 1'b1;
            if (cnt_q == max_d)
               state_d = autorearm_q ? ST_ARMED : ST_DONE;
         end
         default: ;
      endcase

      // Abort overrides everything, including an arm in the same byte and a pulse about to fire.
      if (abort_wr) begin
         state_d  = ST_IDLE;
         glitch_d = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 32'd0;
         d0_q        <= 32'd0;
         d1_q        <= 32'd0;
         en0_q       <= 1'b0;
         en1_q       <= 1'b0;
         autorearm_q <= 1'b0;
         missed_q    <= 1'b0;
         arm_rej_q   <= 1'b0;
         trig_s1_q   <= 1'b0;
         trig_s2_q   <= 1'b0;
         trig_s3_q   <= 1'b0;
         glitch_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         en0_q       <= en0_d;
         en1_q       <= en1_d;
         autorearm_q <= autorearm_d;
         missed_q    <= missed_d;
         arm_rej_q   <= arm_rej_d;
         trig_s1_q   <= trig_s1_d;
         trig_s2_q   <= trig_s2_d;
         trig_s3_q   <= trig_s3_d;
         glitch_q    <= glitch_d;
      end
   end

   // Read data must stay zero unless this slave is addressed, since the bus is OR-combined.
   always_comb begin : readback
      datao      = 8'h00;
      hyplen     = 16'd0;
      delay_word = bus.reg_bytecnt[2] ? d1_q : d0_q;
      if (bus.reg_read) begin
         if (hit_ctrl)
            datao = {3'b000, autorearm_q, en1_q, en0_q, 2'b00};
         else if (hit_delay && bc_in_range)
            datao = delay_word[{bus.reg_bytecnt[1:0], 3'b000} +: 8];
         else if (hit_status)
            datao = {4'h0, arm_rej_q, missed_q, state_q};
      end
      if (bus.reg_hypaddress == SCHED_CTRL_ADDR)
         hyplen = 16'd1;
      else if (bus.reg_hypaddress == SCHED_DELAY_ADDR)
         hyplen = 16'd8;
      else if (bus.reg_hypaddress == SCHED_STATUS_ADDR)
         hyplen = 16'd1;
   end

   assign bus.reg_datao  = datao;
   assign bus.reg_hyplen = hyplen;
   assign glitch_trig_o  = glitch_q;
   assign armed_o        = (state_q == ST_ARMED) || (state_q == ST_RUN);

endmodule

// File: tb/tb_reg_glitchsched.sv
// Bench for reg_glitchsched: a timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus/trigger traffic.
module tb_reg_glitchsched;
   localparam int A_CTRL = 58;
   localparam int A_DLY  = 59;
   localparam int A_STAT = 60;
   localparam int HMAX   = 16384;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig;
   logic [1:0] glitch;
   logic       armed;

   reg_glitchsched_if bus();

   reg_glitchsched dut (
      .clk          (clk),
      .reset_i      (rst),
      .bus          (bus),
      .trig_i       (trig),
      .glitch_trig_o(glitch),
      .armed_o      (armed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;
   int k;
   int p0_edge = -1000, p1_edge = -1000, p0_cnt = 0, p1_cnt = 0;

   // Reference model state: time-stamped rather than counter-based
   bit          hist [0:HMAX-1];
   int          m_state = 0;
   longint      m_start = 0;
   logic [31:0] m_d0 = '0, m_d1 = '0;
   bit          m_en0 = 0, m_en1 = 0, m_ar = 0, m_missed = 0, m_rej = 0;
   bit   [1:0]  m_g = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, n);
      end
   endtask

   task automatic model_step();
      bit     edge_seen, wctl, wdly, arm, abort;
      longint el, mx;
      int     pre, b;
      n++;
      if (rst) begin
         hist[n] = 0;
         if (n >= 1) hist[n-1] = 0;
         if (n >= 2) hist[n-2] = 0;
         m_state = 0; m_d0 = '0; m_d1 = '0;
         m_en0 = 0; m_en1 = 0; m_ar = 0; m_missed = 0; m_rej = 0; m_g = '0;
         return;
      end
      hist[n]   = trig;
      edge_seen = (n >= 3) && hist[n-2] && !hist[n-3];
      wctl  = bus.reg_write && bus.reg_addrvalid && (bus.reg_address == 6'(A_CTRL));
      wdly  = bus.reg_write && bus.reg_addrvalid && (bus.reg_address == 6'(A_DLY));
      arm   = wctl && bus.reg_datai[0];
      abort = wctl && bus.reg_datai[1];
      pre   = m_state;
      m_g   = '0;
      if (m_en0 && m_en1) mx = (m_d0 > m_d1) ? longint'(m_d0) : longint'(m_d1);
      else if (m_en0)     mx = longint'(m_d0);
      else if (m_en1)     mx = longint'(m_d1);
      else                mx = 0;
      case (pre)
         0, 3: if (arm && !abort) begin
                  if (bus.reg_datai[2] || bus.reg_datai[3]) begin m_state = 1; m_missed = 0; end
                  else m_rej = 1;
               end
         1: if (edge_seen) begin m_state = 2; m_start = longint'(n); end
         2: begin
               el = longint'(n) - m_start;
               m_g[0] = m_en0 && (el == longint'(m_d0) + 1);
               m_g[1] = m_en1 && (el == longint'(m_d1) + 1);
               if (edge_seen) m_missed = 1;
               if (el == mx + 1) m_state = m_ar ? 1 : 3;
            end
         default: ;
      endcase
      if (abort) begin m_state = 0; m_g = '0; end
      if (wctl) begin
         m_en0 = bus.reg_datai[2]; m_en1 = bus.reg_datai[3]; m_ar = bus.reg_datai[4];
      end
      b = int'(bus.reg_bytecnt);
      if (wdly && (pre == 0 || pre == 3) && b < 8) begin
         if (b < 4) m_d0[b*8 +: 8] = bus.reg_datai;
         else       m_d1[(b-4)*8 +: 8] = bus.reg_datai;
      end
   endtask

   function automatic logic [7:0] exp_datao();
      int b;
      b = int'(bus.reg_bytecnt);
      if (!(bus.reg_read && bus.reg_addrvalid)) return 8'h00;
      if (bus.reg_address == 6'(A_CTRL)) return {3'b000, m_ar, m_en1, m_en0, 2'b00};
      if (bus.reg_address == 6'(A_DLY)) begin
         if (b < 4) return m_d0[b*8 +: 8];
         if (b < 8) return m_d1[(b-4)*8 +: 8];
         return 8'h00;
      end
      if (bus.reg_address == 6'(A_STAT)) return {4'h0, m_rej, m_missed, 2'(m_state)};
      return 8'h00;
   endfunction

   function automatic logic [15:0] exp_hyplen();
      if (bus.reg_hypaddress == 6'(A_CTRL))  return 16'd1;
      if (bus.reg_hypaddress == 6'(A_DLY))   return 16'd8;
      if (bus.reg_hypaddress == 6'(A_STAT))  return 16'd1;
      return 16'd0;
   endfunction

   always @(posedge clk) begin
      model_step();
      #1;
      chk("glitch_trig_o", 32'(glitch), 32'(m_g));
      chk("armed_o", 32'(armed), 32'(m_state == 1 || m_state == 2));
      chk("reg_datao", 32'(bus.reg_datao), 32'(exp_datao()));
      chk("reg_hyplen", 32'(bus.reg_hyplen), 32'(exp_hyplen()));
      if (glitch[0]) begin p0_edge = n; p0_cnt++; end
      if (glitch[1]) begin p1_edge = n; p1_cnt++; end
   end

   task automatic cyc(input int m);
      repeat (m) @(negedge clk);
   endtask

   task automatic wr(input int a, input int bc, input logic [7:0] d);
      bus.reg_address   = 6'(a);
      bus.reg_bytecnt   = 16'(bc);
      bus.reg_datai     = d;
      bus.reg_write     = 1'b1;
      bus.reg_addrvalid = 1'b1;
      @(negedge clk);
      bus.reg_write     = 1'b0;
      bus.reg_addrvalid = 1'b0;
   endtask

   task automatic wr_dly(input logic [31:0] d0, input logic [31:0] d1);
      for (int i = 0; i < 4; i++) wr(A_DLY, i, d0[i*8 +: 8]);
      for (int i = 0; i < 4; i++) wr(A_DLY, i + 4, d1[i*8 +: 8]);
   endtask

   task automatic rd_chk(input string nm, input int a, input int bc, input logic [7:0] exp);
      bus.reg_address   = 6'(a);
      bus.reg_bytecnt   = 16'(bc);
      bus.reg_read      = 1'b1;
      bus.reg_addrvalid = 1'b1;
      #1;
      chk(nm, 32'(bus.reg_datao), 32'(exp));
      bus.reg_read      = 1'b0;
      bus.reg_addrvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic hyp_chk(input string nm, input int a, input int exp);
      bus.reg_hypaddress = 6'(a);
      #1;
      chk(nm, 32'(bus.reg_hyplen), 32'(exp));
      @(negedge clk);
   endtask

   task automatic clr_pulses();
      p0_cnt = 0; p1_cnt = 0; p0_edge = -1000; p1_edge = -1000;
   endtask

   initial begin
      logic [7:0] d;
      int r, bc;
      rst = 1'b1; trig = 1'b0;
      bus.reg_address = '0; bus.reg_bytecnt = '0; bus.reg_datai = '0;
      bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
      bus.reg_hypaddress = 6'd0;
      cyc(3);
      chk("reset glitch", 32'(glitch), 32'd0);
      chk("reset armed", 32'(armed), 32'd0);
      rst = 1'b0;
      cyc(2);
      rd_chk("reset status", A_STAT, 0, 8'h00);
      rd_chk("reset delay b0", A_DLY, 0, 8'h00);

      // D0=0, D1=5, both channels
      wr_dly(32'd0, 32'd5);
      wr(A_CTRL, 0, 8'h0D);
      rd_chk("t1 status armed", A_STAT, 0, 8'h01);
      clr_pulses();
      trig = 1'b1; k = n + 1;
      cyc(15);
      trig = 1'b0;
      chk("t1 ch0 latency", 32'(p0_edge - k), 32'd3);
      chk("t1 ch1 latency", 32'(p1_edge - k), 32'd8);
      chk("t1 ch0 count", 32'(p0_cnt), 32'd1);
      chk("t1 ch1 count", 32'(p1_cnt), 32'd1);
      rd_chk("t1 status done", A_STAT, 0, 8'h03);

      // autorearm, ch0 only, two triggers
      wr(A_DLY, 0, 8'd10);
      wr(A_DLY, 4, 8'd10);
      wr(A_CTRL, 0, 8'h15);
      clr_pulses();
      trig = 1'b1; cyc(5); trig = 1'b0; cyc(35);
      trig = 1'b1; cyc(5); trig = 1'b0; cyc(25);
      chk("t2 ch0 count", 32'(p0_cnt), 32'd2);
      chk("t2 ch1 count", 32'(p1_cnt), 32'd0);
      chk("t2 armed", 32'(armed), 32'd1);
      rd_chk("t2 status rearmed", A_STAT, 0, 8'h01);
      wr(A_CTRL, 0, 8'h02);

      // second edge during RUN
      wr(A_DLY, 0, 8'd100);
      wr(A_CTRL, 0, 8'h05);
      clr_pulses();
      trig = 1'b1; k = n + 1;
      cyc(3); trig = 1'b0;
      while (n + 1 < k + 20) @(negedge clk);
      trig = 1'b1; cyc(3); trig = 1'b0;
      cyc(100);
      chk("t3 ch0 latency", 32'(p0_edge - k), 32'd103);
      chk("t3 ch0 count", 32'(p0_cnt), 32'd1);
      chk("t3 ch1 count", 32'(p1_cnt), 32'd0);
      rd_chk("t3 status missed", A_STAT, 0, 8'h07);

      // abort at cnt=50
      wr(A_CTRL, 0, 8'h05);
      rd_chk("t4 status rearm clears missed", A_STAT, 0, 8'h01);
      clr_pulses();
      trig = 1'b1; k = n + 1;
      cyc(3); trig = 1'b0;
      while (n < k + 52) @(negedge clk);
      wr(A_CTRL, 0, 8'h02);
      cyc(100);
      chk("t4 no pulse", 32'(p0_cnt), 32'd0);
      chk("t4 armed", 32'(armed), 32'd0);
      rd_chk("t4 status idle", A_STAT, 0, 8'h00);

      // DELAY write locked during RUN; arm with no channel enabled
      wr(A_CTRL, 0, 8'h05);
      trig = 1'b1; cyc(3); trig = 1'b0; cyc(5);
      wr(A_DLY, 0, 8'h33);
      rd_chk("t5 delay locked", A_DLY, 0, 8'h64);
      rd_chk("t5 status run", A_STAT, 0, 8'h02);
      wr(A_CTRL, 0, 8'h02);
      wr(A_CTRL, 0, 8'h01);
      rd_chk("t5 status rejected", A_STAT, 0, 8'h08);
      rd_chk("t5 ctrl reads", A_CTRL, 0, 8'h00);

      // length query, foreign read, reset mid-run
      hyp_chk("hyplen delay", A_DLY, 8);
      hyp_chk("hyplen ctrl", A_CTRL, 1);
      hyp_chk("hyplen status", A_STAT, 1);
      hyp_chk("hyplen foreign", 33, 0);
      rd_chk("foreign read", 30, 0, 8'h00);
      rd_chk("delay b4", A_DLY, 4, 8'h0A);
      rd_chk("delay b9 out of range", A_DLY, 9, 8'h00);
      wr(A_CTRL, 0, 8'h0D);
      clr_pulses();
      trig = 1'b1; cyc(3); trig = 1'b0; cyc(6);
      rst = 1'b1; cyc(1);
      chk("reset mid-run glitch", 32'(glitch), 32'd0);
      chk("reset mid-run armed", 32'(armed), 32'd0);
      rst = 1'b0;
      cyc(120);
      chk("reset mid-run ch0", 32'(p0_cnt), 32'd0);
      chk("reset mid-run ch1", 32'(p1_cnt), 32'd0);
      rd_chk("reset clears delay", A_DLY, 0, 8'h00);
      rd_chk("reset clears status", A_STAT, 0, 8'h00);

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         bus.reg_write = 1'b0; bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            d = 8'($urandom_range(0, 255));
            d[0] = ($urandom_range(0, 1) == 0);
            d[1] = ($urandom_range(0, 15) == 0);
            bus.reg_address = 6'(A_CTRL); bus.reg_bytecnt = 16'd0; bus.reg_datai = d;
            bus.reg_write = 1'b1; bus.reg_addrvalid = ($urandom_range(0, 9) != 0);
         end else if (r < 20) begin
            bc = $urandom_range(0, 9);
            if (bc == 0 || bc == 4) d = 8'($urandom_range(0, 30));
            else if (bc > 7)        d = 8'($urandom_range(0, 255));
            else                    d = 8'h00;
            bus.reg_address = 6'(A_DLY); bus.reg_bytecnt = 16'(bc); bus.reg_datai = d;
            bus.reg_write = 1'b1; bus.reg_addrvalid = ($urandom_range(0, 9) != 0);
         end else if (r < 45) begin
            case ($urandom_range(0, 3))
               0: bus.reg_address = 6'(A_CTRL);
               1: bus.reg_address = 6'(A_DLY);
               2: bus.reg_address = 6'(A_STAT);
               default: bus.reg_address = 6'($urandom_range(0, 63));
            endcase
            bus.reg_bytecnt = 16'($urandom_range(0, 9));
            bus.reg_datai = 8'($urandom_range(0, 255));
            bus.reg_read = 1'b1; bus.reg_addrvalid = ($urandom_range(0, 3) != 0);
         end
         bus.reg_hypaddress = 6'($urandom_range(54, 63));
         if ($urandom_range(0, 5) == 0) trig = ~trig;
         rst = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      bus.reg_write = 1'b0; bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
      cyc(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
